// File: rtl/asic_palette_rgb_pkg.sv
// Shared types and constants for the Plus ASIC palette block.
// Contents:
//   rgb12_t      packed {R[3:0], G[3:0], B[3:0]} colour
//   pen_idx_t    5-bit palette entry index (0..31)
//   PAL_BASE     default CPU base address of the 64-byte palette window
//   PEN_BORDER   entry used while display enable is low
//   PEN_SPRITE0  offset added to a sprite pen to reach its entry
//   PAL_ENTRIES  number of palette entries
//   pen_select   pixel source priority: border > sprite > ink
package asic_pkg;

    typedef logic [11:0] rgb12_t;
    typedef logic [4:0]  pen_idx_t;

    localparam logic [15:0] PAL_BASE    = 16'h6400;
    localparam pen_idx_t    PEN_BORDER  = 5'd16;
    localparam pen_idx_t    PEN_SPRITE0 = 5'd16;
    localparam int          PAL_ENTRIES = 32;

    // Border wins over everything; an opaque sprite pixel wins over ink.
    // Sprite pens 1..15 land on entries 17..31.
    function automatic pen_idx_t pen_select(input logic de,
                                            input logic [3:0] sprite_pen,
                                            input logic [3:0] ink_pen);
        pen_idx_t idx;
        if (!de) begin
            idx = PEN_BORDER;
        end else if (sprite_pen != 4'd0) begin
            idx = PEN_SPRITE0 + {1'b0, sprite_pen};
        end else begin
            idx = {1'b0, ink_pen};
        end
        return idx;
    endfunction

endpackage

// File: rtl/asic_palette_rgb_if.sv
// Bus bundle between the CPU/gate-array side and the palette block.
// Signals:
//   cpu_addr/cpu_data/cpu_wr/cpu_rd   CPU access (strobes are one cycle wide)
//   cpu_dout/cpu_dout_valid           readback, valid pulses for one cycle
//   pix_en/ink_pen/sprite_pen/de/hblank/vblank   per-pixel stream
//   r_out/g_out/b_out                 registered 4:4:4 colour
// Strobe semantics: cpu_wr and cpu_rd are sampled on a single clock edge;
// there is no back-pressure, the block always accepts. A read that hits
// returns data on the following cycle with cpu_dout_valid high for exactly
// that cycle. pix_en qualifies the pixel inputs on the edge where it is high.
interface asic_palette_rgb_if;

    logic [15:0] cpu_addr;
    logic [7:0]  cpu_data;
    logic        cpu_wr;
    logic        cpu_rd;
    logic [7:0]  cpu_dout;
    logic        cpu_dout_valid;
    logic        pix_en;
    logic [3:0]  ink_pen;
    logic [3:0]  sprite_pen;
    logic        de;
    logic        hblank;
    logic        vblank;
    logic [3:0]  r_out;
    logic [3:0]  g_out;
    logic [3:0]  b_out;

    // Driver side: CPU plus gate array.
    modport master (
        output cpu_addr, cpu_data, cpu_wr, cpu_rd,
        output pix_en, ink_pen, sprite_pen, de, hblank, vblank,
        input  cpu_dout, cpu_dout_valid, r_out, g_out, b_out
    );

    // Palette block side.
    modport slave (
        input  cpu_addr, cpu_data, cpu_wr, cpu_rd,
        input  pix_en, ink_pen, sprite_pen, de, hblank, vblank,
        output cpu_dout, cpu_dout_valid, r_out, g_out, b_out
    );

endinterface

// File: rtl/asic_palette_rgb_ram.sv
// 32 x 12-bit palette storage built from flops.
// Ports:
//   clk, reset_n   clock, async active-low reset (entries load RESET_RGB)
//   we_lo          write byte 0 lane: R <= wr_data[7:4], B <= wr_data[3:0]
//   we_hi          write byte 1 lane: G <= wr_data[3:0]
//   wr_idx         entry written
//   wr_data        CPU byte
//   cpu_idx/cpu_rgb  async read port for CPU readback
//   pix_idx/pix_rgb  async read port for pixel lookup
// Read ports return the pre-write contents on a write edge, so a lookup on
// the same edge as a write sees the old colour.
module asic_palette_ram
    import asic_pkg::*;
#(
    parameter rgb12_t RESET_RGB = 12'h000
) (
    input  logic     clk,
    input  logic     reset_n,
    input  logic     we_lo,
    input  logic     we_hi,
    input  pen_idx_t wr_idx,
    input  logic [7:0] wr_data,
    input  pen_idx_t cpu_idx,
    output rgb12_t   cpu_rgb,
    input  pen_idx_t pix_idx,
    output rgb12_t   pix_rgb
);

    rgb12_t mem [PAL_ENTRIES];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < PAL_ENTRIES; i++) begin
                mem[i] <= RESET_RGB;
            end
        end else begin
            // Lanes are independent: a single-byte write keeps the other lane.
            if (we_lo) begin
                mem[wr_idx][11:8] <= wr_data[7:4];
                mem[wr_idx][3:0]  <= wr_data[3:0];
            end
            if (we_hi) begin
                mem[wr_idx][7:4]  <= wr_data[3:0];
            end
        end
    end

    assign cpu_rgb = mem[cpu_idx];
    assign pix_rgb = mem[pix_idx];

endmodule

// File: rtl/asic_palette_rgb.sv
// Plus ASIC colour source: palette RAM, CPU window and pixel pipeline.
// Ports:
//   clk_sys        system clock
//   reset_n        async active-low reset
//   plus_mode      Plus features enabled; when low, colour is black and CPU
//                  accesses are ignored (palette contents are retained)
//   asic_unlocked  ASIC page mapped; when low, CPU accesses are ignored
//   bus            slave side of asic_palette_rgb_if (CPU + pixel stream + RGB)
// Pixel path: stage 1 registers the selected entry index and blank flag,
// stage 2 registers the looked-up colour. Both advance only on pix_en, so an
// input pixel reaches r/g/b_out on the second pix_en strobe.
module asic_palette_rgb
    import asic_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = PAL_BASE,
    parameter rgb12_t      RESET_RGB = 12'h000
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    input  logic                  plus_mode,
    input  logic                  asic_unlocked,
    asic_palette_rgb_if.slave     bus
);

    logic     hit;
    pen_idx_t cpu_idx;
    logic     we_lo;
    logic     we_hi;
    logic     rd_ok;
    rgb12_t   cpu_rgb;
    rgb12_t   pix_rgb;

    pen_idx_t s1_idx;
    logic     s1_blk;
    rgb12_t   s2_rgb;
    logic [7:0] dout_q;
    logic       dout_valid_q;

    // 64-byte window; entry is the word index, bit 0 selects the lane.
    assign hit     = plus_mode & asic_unlocked &
                     (bus.cpu_addr[15:6] == BASE_ADDR[15:6]);
    assign cpu_idx = bus.cpu_addr[5:1];
    assign we_lo   = bus.cpu_wr & hit & ~bus.cpu_addr[0];
    assign we_hi   = bus.cpu_wr & hit &  bus.cpu_addr[0];
    // A simultaneous write takes the cycle; the read is dropped.
    assign rd_ok   = bus.cpu_rd & hit & ~bus.cpu_wr;

    asic_palette_ram #(
        .RESET_RGB (RESET_RGB)
    ) u_ram (
        .clk     (clk_sys),
        .reset_n (reset_n),
        .we_lo   (we_lo),
        .we_hi   (we_hi),
        .wr_idx  (cpu_idx),
        .wr_data (bus.cpu_data),
        .cpu_idx (cpu_idx),
        .cpu_rgb (cpu_rgb),
        .pix_idx (s1_idx),
        .pix_rgb (pix_rgb)
    );

    // CPU readback: byte 0 = {R,B}, byte 1 = {0,G}. Data holds when idle.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            dout_q       <= 8'h00;
            dout_valid_q <= 1'b0;
        end else begin
            dout_valid_q <= rd_ok;
            if (rd_ok) begin
                if (bus.cpu_addr[0]) begin
                    dout_q <= {4'h0, cpu_rgb[7:4]};
                end else begin
                    dout_q <= {cpu_rgb[11:8], cpu_rgb[3:0]};
                end
            end
        end
    end

    // Two-stage pixel pipeline gated by pix_en.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            s1_idx <= '0;
            s1_blk <= 1'b0;
            s2_rgb <= '0;
        end else if (bus.pix_en) begin
            s1_idx <= pen_select(bus.de, bus.sprite_pen, bus.ink_pen);
            s1_blk <= bus.hblank | bus.vblank;
            // Blanking and non-Plus mode both force black at the output stage.
            s2_rgb <= (s1_blk | ~plus_mode) ? 12'h000 : pix_rgb;
        end
    end

    assign bus.cpu_dout       = dout_q;
    assign bus.cpu_dout_valid = dout_valid_q;
    assign bus.r_out          = s2_rgb[11:8];
    assign bus.g_out          = s2_rgb[7:4];
    assign bus.b_out          = s2_rgb[3:0];

endmodule
